// File: rtl/tcdm_prio_ctrl_pkg.sv
// Shared types for the TCDM heterogeneous-interconnect priority controller.
package hci_package;

  localparam int unsigned HCI_STALL_W = 8;

  typedef enum logic [1:0] {
    PRIO_FIX_LOG  = 2'd0,
    PRIO_FIX_HWPE = 2'd1,
    PRIO_STALL    = 2'd2,
    PRIO_SLICE    = 2'd3
  } hci_prio_policy_e;

  typedef enum logic {
    PRIO_LOG  = 1'b0,
    PRIO_HWPE = 1'b1
  } hci_prio_state_e;

  typedef struct packed {
    hci_prio_policy_e         policy;
    logic [HCI_STALL_W-1:0]   max_stall;
    logic [HCI_STALL_W-1:0]   slice_log;
    logic [HCI_STALL_W-1:0]   slice_hwpe;
  } hci_prio_cfg_t;

endpackage

// File: rtl/tcdm_prio_ctrl_cnt.sv
// Stall/slice counter with clear, increment and terminal-count detection.
// A zero threshold is treated as one so the counter can never run past it.
module tcdm_prio_cnt
  import hci_package::*;
#(
  parameter int unsigned W = HCI_STALL_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] thresh_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] thresh_eff;

  assign thresh_eff = (thresh_i == '0) ? W'(1) : thresh_i;

  // Widened by one bit so the +1 never aliases back to zero.
  assign tc_o  = ({1'b0, cnt_q} + (W+1)'(1)) == {1'b0, thresh_eff};
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tcdm_prio_ctrl.sv
// Priority sequencer between the log branch and the HWPE branch of the TCDM
// interconnect: fixed, stall-bounded or time-sliced policies.
module tcdm_prio_ctrl
  import hci_package::*;
#(
  parameter int unsigned NB_LOG  = 16,
  parameter int unsigned STALL_W = HCI_STALL_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NB_LOG-1:0]  log_req_i,
  input  logic [NB_LOG-1:0]  log_gnt_i,
  input  logic               hwpe_req_i,
  input  logic               hwpe_gnt_i,
  input  logic               cfg_valid_i,
  input  logic [1:0]         cfg_policy_i,
  input  logic [STALL_W-1:0] cfg_max_stall_i,
  input  logic [STALL_W-1:0] cfg_slice_log_i,
  input  logic [STALL_W-1:0] cfg_slice_hwpe_i,
  output logic               hwpe_prio_o,
  output logic [STALL_W-1:0] cnt_o,
  output logic               swap_evt_o
);

  hci_prio_cfg_t   cfg_q, cfg_d;
  hci_prio_state_e state_q, state_d, state_flip;
  logic            swap_evt_q, swap_evt_d;

  logic               cnt_clr, cnt_inc, cnt_tc;
  logic [STALL_W-1:0] cnt_val, cnt_thresh;

  logic log_req_any, log_stall, hwpe_stall;
  logic loser_stall, owner_req, loser_req;

  assign log_req_any = |log_req_i;
  assign log_stall   = |(log_req_i & ~log_gnt_i);
  assign hwpe_stall  = hwpe_req_i & ~hwpe_gnt_i;

  assign loser_stall = (state_q == PRIO_LOG) ? hwpe_stall  : log_stall;
  assign owner_req   = (state_q == PRIO_LOG) ? log_req_any : hwpe_req_i;
  assign loser_req   = (state_q == PRIO_LOG) ? hwpe_req_i  : log_req_any;
  assign state_flip  = (state_q == PRIO_LOG) ? PRIO_HWPE   : PRIO_LOG;

  always_comb begin
    cnt_thresh = '0;
    case (cfg_q.policy)
      PRIO_STALL: cnt_thresh = STALL_W'(cfg_q.max_stall);
      PRIO_SLICE: cnt_thresh = (state_q == PRIO_HWPE) ? STALL_W'(cfg_q.slice_hwpe)
                                                      : STALL_W'(cfg_q.slice_log);
      default:    cnt_thresh = '0;
    endcase
  end

  tcdm_prio_cnt #(
    .W (STALL_W)
  ) i_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .thresh_i (cnt_thresh),
    .cnt_o    (cnt_val),
    .tc_o     (cnt_tc)
  );

  // A config load takes precedence over any swap condition in the same cycle.
  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    if (cfg_valid_i) begin
      cfg_d.policy     = hci_prio_policy_e'(cfg_policy_i);
      cfg_d.max_stall  = HCI_STALL_W'(cfg_max_stall_i);
      cfg_d.slice_log  = HCI_STALL_W'(cfg_slice_log_i);
      cfg_d.slice_hwpe = HCI_STALL_W'(cfg_slice_hwpe_i);
      cnt_clr          = 1'b1;
      if (cfg_policy_i == PRIO_FIX_LOG) begin
        state_d = PRIO_LOG;
      end else if (cfg_policy_i == PRIO_FIX_HWPE) begin
        state_d = PRIO_HWPE;
      end
    end else begin
      case (cfg_q.policy)
        PRIO_FIX_LOG: begin
          state_d = PRIO_LOG;
          cnt_clr = 1'b1;
        end
        PRIO_FIX_HWPE: begin
          state_d = PRIO_HWPE;
          cnt_clr = 1'b1;
        end
        PRIO_STALL: begin
          if (!loser_stall) begin
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            state_d = state_flip;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        PRIO_SLICE: begin
          // An idle owner hands over at once rather than wasting its slice.
          if ((!owner_req && loser_req) || cnt_tc) begin
            state_d = state_flip;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    swap_evt_d = (state_d != state_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q      <= '{policy: PRIO_FIX_LOG, max_stall: '0, slice_log: '0, slice_hwpe: '0};
      state_q    <= PRIO_LOG;
      swap_evt_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      state_q    <= state_d;
      swap_evt_q <= swap_evt_d;
    end
  end

  assign hwpe_prio_o = (state_q == PRIO_HWPE);
  assign cnt_o       = cnt_val;
  assign swap_evt_o  = swap_evt_q;

endmodule

// File: tb/tb_tcdm_prio_ctrl.sv
// Scoreboard bench for tcdm_prio_ctrl: a behavioural model pushes the expected
// outputs each cycle, and they are popped and compared after the clock edge.
module tb_tcdm_prio_ctrl;
  import hci_package::*;

  localparam int NB_LOG  = 16;
  localparam int STALL_W = 8;

  logic clk = 1'b0;
  logic rstN;
  logic [NB_LOG-1:0]  logReq, logGnt;
  logic               hwpeReq, hwpeGnt, cfgValid;
  logic [1:0]         cfgPolicy;
  logic [STALL_W-1:0] cfgMaxStall, cfgSliceLog, cfgSliceHwpe;
  logic               hwpePrio, swapEvt;
  logic [STALL_W-1:0] cnt;

  int errCount   = 0;
  int checkCount = 0;

  typedef struct {
    bit prio;
    int cnt;
    bit evt;
  } exp_t;
  exp_t sbQ[$];

  int mPol, mMax, mSliceLog, mSliceHwpe, mCnt;
  bit mState, mEvt;

  int t3Cnt[5] = '{1, 2, 0, 1, 2};
  logic [11:0] t4Pattern;
  int t4Evts;

  always #5 clk = ~clk;

  tcdm_prio_ctrl #(
    .NB_LOG  (NB_LOG),
    .STALL_W (STALL_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .log_req_i        (logReq),
    .log_gnt_i        (logGnt),
    .hwpe_req_i       (hwpeReq),
    .hwpe_gnt_i       (hwpeGnt),
    .cfg_valid_i      (cfgValid),
    .cfg_policy_i     (cfgPolicy),
    .cfg_max_stall_i  (cfgMaxStall),
    .cfg_slice_log_i  (cfgSliceLog),
    .cfg_slice_hwpe_i (cfgSliceHwpe),
    .hwpe_prio_o      (hwpePrio),
    .cnt_o            (cnt),
    .swap_evt_o       (swapEvt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mPol = 0; mMax = 0; mSliceLog = 0; mSliceHwpe = 0;
    mCnt = 0; mState = 1'b0; mEvt = 1'b0;
  endtask

  task automatic modelStep();
    bit logStall, hwpeStall, loserStall, ownerReq, loserReq, nState;
    int nCnt, lim;
    logStall  = |(logReq & ~logGnt);
    hwpeStall = hwpeReq & ~hwpeGnt;
    nState = mState;
    nCnt   = mCnt;
    if (cfgValid) begin
      mPol       = int'(cfgPolicy);
      mMax       = int'(cfgMaxStall);
      mSliceLog  = int'(cfgSliceLog);
      mSliceHwpe = int'(cfgSliceHwpe);
      nCnt = 0;
      if (mPol == 0) nState = 1'b0;
      else if (mPol == 1) nState = 1'b1;
    end else if (mPol == 0) begin
      nState = 1'b0; nCnt = 0;
    end else if (mPol == 1) begin
      nState = 1'b1; nCnt = 0;
    end else if (mPol == 2) begin
      lim = (mMax == 0) ? 1 : mMax;
      loserStall = mState ? logStall : hwpeStall;
      if (!loserStall) nCnt = 0;
      else if (mCnt + 1 == lim) begin nState = !mState; nCnt = 0; end
      else nCnt = mCnt + 1;
    end else begin
      lim = mState ? mSliceHwpe : mSliceLog;
      if (lim == 0) lim = 1;
      ownerReq = mState ? hwpeReq : (|logReq);
      loserReq = mState ? (|logReq) : hwpeReq;
      if ((!ownerReq && loserReq) || (mCnt + 1 == lim)) begin nState = !mState; nCnt = 0; end
      else nCnt = mCnt + 1;
    end
    mEvt   = (nState != mState);
    mState = nState;
    mCnt   = nCnt;
    sbQ.push_back('{prio: mState, cnt: mCnt, evt: mEvt});
  endtask

  task automatic applyStimulus(input string tag);
    exp_t e;
    modelStep();
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "_prio"}, 32'(hwpePrio), 32'(e.prio));
      checkOutput({tag, "_cnt"},  32'(cnt),      32'(e.cnt));
      checkOutput({tag, "_evt"},  32'(swapEvt),  32'(e.evt));
    end
    cfgValid = 1'b0;
  endtask

  task automatic cfgLoad(input int pol, input int maxStall, input int sl, input int sh, input string tag);
    cfgPolicy    = 2'(pol);
    cfgMaxStall  = 8'(maxStall);
    cfgSliceLog  = 8'(sl);
    cfgSliceHwpe = 8'(sh);
    cfgValid     = 1'b1;
    applyStimulus(tag);
  endtask

  task automatic setIdle();
    logReq = '0; logGnt = '0; hwpeReq = 1'b0; hwpeGnt = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    setIdle();
    cfgValid = 1'b0; cfgPolicy = '0; cfgMaxStall = '0; cfgSliceLog = '0; cfgSliceHwpe = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_prio", 32'(hwpePrio), 32'd0);
    checkOutput("rst_cnt",  32'(cnt),      32'd0);
    checkOutput("rst_evt",  32'(swapEvt),  32'd0);
    rstN = 1'b1;

    // No config: fixed log priority whatever the traffic.
    for (int i = 0; i < 20; i++) begin
      logReq  = 16'($urandom);
      logGnt  = 16'($urandom);
      hwpeReq = 1'($urandom_range(0, 1));
      hwpeGnt = 1'($urandom_range(0, 1));
      applyStimulus("t1");
    end

    setIdle();
    cfgLoad(2, 3, 0, 0, "t2_cfg");
    hwpeReq = 1'b1; hwpeGnt = 1'b0;
    applyStimulus("t2_s1"); checkOutput("t2_cnt1", 32'(cnt), 32'd1);
    applyStimulus("t2_s2"); checkOutput("t2_cnt2", 32'(cnt), 32'd2);
    applyStimulus("t2_s3");
    checkOutput("t2_swap", 32'(swapEvt), 32'd1);
    checkOutput("t2_prio", 32'(hwpePrio), 32'd1);
    checkOutput("t2_cnt0", 32'(cnt), 32'd0);
    hwpeReq = 1'b0; logReq[5] = 1'b1; logGnt = '0;
    applyStimulus("t2_b1");
    applyStimulus("t2_b2");
    applyStimulus("t2_b3");
    checkOutput("t2_back_prio", 32'(hwpePrio), 32'd0);
    checkOutput("t2_back_evt",  32'(swapEvt),  32'd1);

    setIdle();
    cfgLoad(2, 3, 0, 0, "t3_cfg");
    for (int i = 0; i < 5; i++) begin
      hwpeReq = 1'b1;
      hwpeGnt = (i == 2);
      applyStimulus("t3");
      checkOutput("t3_seq_cnt", 32'(cnt), 32'(t3Cnt[i]));
      checkOutput("t3_noswap", 32'(hwpePrio), 32'd0);
    end

    setIdle();
    cfgLoad(0, 0, 0, 0, "t4_fix");
    logReq = 16'h0001; hwpeReq = 1'b1;
    t4Pattern = '0; t4Evts = 0;
    cfgLoad(3, 0, 4, 2, "t4_cfg");
    t4Pattern = {t4Pattern[10:0], hwpePrio};
    t4Evts += int'(swapEvt);
    for (int i = 0; i < 11; i++) begin
      applyStimulus("t4");
      t4Pattern = {t4Pattern[10:0], hwpePrio};
      t4Evts += int'(swapEvt);
    end
    checkOutput("t4_pattern", 32'(t4Pattern), 32'(12'b000011000011));
    checkOutput("t4_evts", 32'(t4Evts), 32'd3);

    setIdle();
    cfgLoad(0, 0, 0, 0, "t5_fix");
    hwpeReq = 1'b1;
    cfgLoad(3, 0, 4, 4, "t5_cfg");
    applyStimulus("t5_skip");
    checkOutput("t5_skip_prio", 32'(hwpePrio), 32'd1);
    checkOutput("t5_skip_evt",  32'(swapEvt),  32'd1);
    hwpeReq = 1'b0; logReq = 16'h0100;
    cfgLoad(3, 0, 4, 4, "t5_cfgwin");
    checkOutput("t5_win_prio", 32'(hwpePrio), 32'd1);
    checkOutput("t5_win_evt",  32'(swapEvt),  32'd0);
    checkOutput("t5_win_cnt",  32'(cnt),      32'd0);
    applyStimulus("t5_after");
    checkOutput("t5_after_prio", 32'(hwpePrio), 32'd0);

    setIdle();
    cfgLoad(0, 0, 0, 0, "t6_fix");
    cfgLoad(2, 5, 0, 0, "t6_stall");
    hwpeReq = 1'b1; hwpeGnt = 1'b0;
    applyStimulus("t6_s1");
    applyStimulus("t6_s2");
    checkOutput("t6_cnt2", 32'(cnt), 32'd2);
    cfgLoad(1, 0, 0, 0, "t6_fixhwpe");
    checkOutput("t6_prio", 32'(hwpePrio), 32'd1);
    checkOutput("t6_evt",  32'(swapEvt),  32'd1);
    checkOutput("t6_cnt0", 32'(cnt),      32'd0);
    applyStimulus("t6_hold");
    logReq = 16'h8000;
    cfgLoad(3, 0, 3, 3, "t6_slice");
    applyStimulus("t6_sl1");
    applyStimulus("t6_sl2");
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6_arst_prio", 32'(hwpePrio), 32'd0);
    checkOutput("t6_arst_cnt",  32'(cnt),      32'd0);
    checkOutput("t6_arst_evt",  32'(swapEvt),  32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logReq  = 16'($urandom);
      hwpeReq = 1'b1;
      applyStimulus("t6_post");
    end

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
